// File: rtl/prbs13_pkg.sv
// Shared PRBS13 definitions: LFSR width, tap mask, generator seed and checker state encoding.
package prbs13_pkg;

   localparam int unsigned PRBS_W   = 13;
   // Taps at bits 12, 3, 2 and 0.
   localparam logic [12:0] TAP_MASK = 13'h100D;
   localparam logic [12:0] GEN_SEED = 13'h0245;

   typedef enum logic [1:0] {
      ST_SEED  = 2'd0,
      ST_CHECK = 2'd1,
      ST_LOCK  = 2'd2
   } chk_state_e;

   function automatic logic lfsr_fb(input logic [12:0] s);
      return ^(s & TAP_MASK);
   endfunction

endpackage

// File: rtl/prbs13_checker_if.sv
// Serial data / status bundle of the PRBS13 checker; inj_err exists only with PRBS13_CHK_INJECT_EN.
interface prbs13_checker_if;

   logic        in_valid;
   logic        in_bit;
   logic        clear_counts;
`ifdef PRBS13_CHK_INJECT_EN
   logic        inj_err;
`endif
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [12:0] expected;

`ifdef PRBS13_CHK_INJECT_EN
   modport master (output in_valid, in_bit, clear_counts, inj_err,
                   input  locked, err_pulse, err_count, expected);
   modport slave  (input  in_valid, in_bit, clear_counts, inj_err,
                   output locked, err_pulse, err_count, expected);
`else
   modport master (output in_valid, in_bit, clear_counts,
                   input  locked, err_pulse, err_count, expected);
   modport slave  (input  in_valid, in_bit, clear_counts,
                   output locked, err_pulse, err_count, expected);
`endif

endinterface

// File: rtl/prbs13_step.sv
// One combinational PRBS13 LFSR step, shared by checker and generator.
module prbs13_step
   import prbs13_pkg::*;
(
   input  logic [PRBS_W-1:0] state,
   output logic              fb,
   output logic [PRBS_W-1:0] next
);

   assign fb   = lfsr_fb(state);
   assign next = {state[PRBS_W-2:0], fb};

endmodule

// File: rtl/prbs13_checker.sv
// PRBS13 checker: seeds from the line, self-syncs, then flywheels and counts errors per window.
// Optional error injection input enabled by PRBS13_CHK_INJECT_EN.
module prbs13_checker
   import prbs13_pkg::*;
#(
   parameter int MATCH_LOCK  = 26,
   parameter int LOSS_THRESH = 4,
   parameter int WINDOW      = 64
) (
   input  logic             clock,
   input  logic             reset,
   prbs13_checker_if.slave  bus
);

   localparam int MC_W = $clog2(MATCH_LOCK + 1);
   localparam int WB_W = $clog2(WINDOW);
   localparam int WE_W = $clog2(LOSS_THRESH + 1);

   chk_state_e          state_q, state_d;
   logic [12:0]         expected_q, expected_d;
   logic [3:0]          seed_cnt_q, seed_cnt_d;
   logic [MC_W-1:0]     match_cnt_q, match_cnt_d;
   logic [WB_W-1:0]     win_bit_q, win_bit_d;
   logic [WE_W-1:0]     win_err_q, win_err_d;
   logic [15:0]         err_count_q, err_count_d;
   logic                err_pulse_q, err_pulse_d;
   logic                locked_q, locked_d;

   logic                rx_bit_s;
   logic                pred_fb_s;
   logic [12:0]         pred_next_s;
   logic                mismatch_s;
   logic [12:0]         shifted_rx_s;
   logic [WE_W-1:0]     win_err_new_s;

`ifdef PRBS13_CHK_INJECT_EN
   assign rx_bit_s = bus.in_bit ^ bus.inj_err;
`else
   assign rx_bit_s = bus.in_bit;
`endif

   prbs13_step u_step (
      .state (expected_q),
      .fb    (pred_fb_s),
      .next  (pred_next_s)
   );

   assign mismatch_s   = rx_bit_s ^ pred_fb_s;
   assign shifted_rx_s = {expected_q[11:0], rx_bit_s};

   // Next-state and counter logic; idle cycles hold everything and drop err_pulse.
   always_comb begin
      state_d       = state_q;
      expected_d    = expected_q;
      seed_cnt_d    = seed_cnt_q;
      match_cnt_d   = match_cnt_q;
      win_bit_d     = win_bit_q;
      win_err_d     = win_err_q;
      err_count_d   = err_count_q;
      err_pulse_d   = 1'b0;
      win_err_new_s = win_err_q;
      if (bus.in_valid) begin
         case (state_q)
            ST_SEED: begin
               expected_d = shifted_rx_s;
               if (seed_cnt_q == 4'd12) begin
                  seed_cnt_d  = 4'd0;
                  match_cnt_d = '0;
                  state_d     = (shifted_rx_s == 13'h0000) ? ST_SEED : ST_CHECK;
               end else begin
                  seed_cnt_d = seed_cnt_q + 4'd1;
               end
            end
            ST_CHECK: begin
               expected_d = shifted_rx_s;
               if (mismatch_s) begin
                  match_cnt_d = '0;
               end else if (match_cnt_q == MC_W'(MATCH_LOCK - 1)) begin
                  match_cnt_d = '0;
                  win_bit_d   = '0;
                  win_err_d   = '0;
                  state_d     = ST_LOCK;
               end else begin
                  match_cnt_d = match_cnt_q + {{(MC_W-1){1'b0}}, 1'b1};
               end
            end
            ST_LOCK: begin
               // Flywheel: the prediction, not the received bit, advances the LFSR.
               expected_d  = pred_next_s;
               err_pulse_d = mismatch_s;
               if (mismatch_s && (err_count_q != 16'hFFFF)) begin
                  err_count_d = err_count_q + 16'd1;
               end else begin
                  err_count_d = err_count_q;
               end
               if (win_bit_q == WB_W'(WINDOW - 1)) begin
                  win_bit_d     = '0;
                  win_err_new_s = {{(WE_W-1){1'b0}}, mismatch_s};
               end else begin
                  win_bit_d     = win_bit_q + {{(WB_W-1){1'b0}}, 1'b1};
                  win_err_new_s = win_err_q + {{(WE_W-1){1'b0}}, mismatch_s};
               end
               if (win_err_new_s == WE_W'(LOSS_THRESH)) begin
                  state_d    = ST_SEED;
                  seed_cnt_d = 4'd0;
                  win_bit_d  = '0;
                  win_err_d  = '0;
               end else begin
                  win_err_d  = win_err_new_s;
               end
            end
            default: begin
               state_d    = ST_SEED;
               seed_cnt_d = 4'd0;
            end
         endcase
      end else begin
         err_pulse_d = 1'b0;
      end
      if (bus.clear_counts) begin
         err_count_d = 16'h0000;
      end else begin
         err_count_d = err_count_d;
      end
      locked_d = (state_d == ST_LOCK);
   end

   // State and counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SEED;
         expected_q  <= 13'h0000;
         seed_cnt_q  <= 4'd0;
         match_cnt_q <= '0;
         win_bit_q   <= '0;
         win_err_q   <= '0;
         err_count_q <= 16'h0000;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_bit_q   <= win_bit_d;
         win_err_q   <= win_err_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= locked_d;
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count_q;
   assign bus.expected  = expected_q;

endmodule

// File: tb/tb_prbs13_checker.sv
// Directed bench for prbs13_checker: phase table over a reference PRBS13 stream plus corner sequences.
module tb_prbs13_checker;

   logic clock = 1'b0;
   logic reset;

   prbs13_checker_if ifc ();

   prbs13_checker #(
      .MATCH_LOCK  (26),
      .LOSS_THRESH (4),
      .WINDOW      (64)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      int          nbits;
      int          nflips;
      logic        exp_locked;
      logic [15:0] exp_cnt;
      int          exp_pulses;
   } phase_t;

   phase_t      tbl [12];
   int          checks   = 0;
   int          failures = 0;
   int          pulses   = 0;
   logic [12:0] gen_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference far-end generator: emit feedback bit, shift it in.
   task automatic gen_bit(output logic b);
      logic fb;
      fb    = gen_q[12] ^ gen_q[3] ^ gen_q[2] ^ gen_q[0];
      gen_q = {gen_q[11:0], fb};
      b     = fb;
   endtask

   task automatic send(input logic b, input logic v, input logic clr);
      @(negedge clock);
      ifc.in_valid     = v;
      ifc.in_bit       = b;
      ifc.clear_counts = clr;
      @(posedge clock);
      #1;
      if (ifc.err_pulse === 1'b1) pulses++;
      ifc.in_valid     = 1'b0;
      ifc.clear_counts = 1'b0;
   endtask

   task automatic send_gen(input logic flip, input logic clr);
      logic b;
      gen_bit(b);
      send(b ^ flip, 1'b1, clr);
   endtask

   task automatic send_clean(input int n);
      for (int i = 0; i < n; i++) send_gen(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{"seed13",       13,  0, 1'b0, 16'h0000, 0};
      tbl[1]  = '{"check25",      25,  0, 1'b0, 16'h0000, 0};
      tbl[2]  = '{"lock_bit39",    1,  0, 1'b1, 16'h0000, 0};
      tbl[3]  = '{"clean100",    100,  0, 1'b1, 16'h0000, 0};
      tbl[4]  = '{"one_flip",     20,  1, 1'b1, 16'h0001, 1};
      tbl[5]  = '{"flywheel",    200,  0, 1'b1, 16'h0001, 0};
      tbl[6]  = '{"three_in_win", 24,  3, 1'b1, 16'h0004, 3};
      tbl[7]  = '{"fill_win",     39,  0, 1'b1, 16'h0004, 0};
      tbl[8]  = '{"wrap_flip",     1,  1, 1'b1, 16'h0005, 1};
      tbl[9]  = '{"lose_lock",    17,  3, 1'b0, 16'h0008, 3};
      tbl[10] = '{"reseed38",     38,  0, 1'b0, 16'h0008, 0};
      tbl[11] = '{"relock",        1,  0, 1'b1, 16'h0008, 0};

      reset            = 1'b1;
      ifc.in_valid     = 1'b0;
      ifc.in_bit       = 1'b0;
      ifc.clear_counts = 1'b0;
`ifdef PRBS13_CHK_INJECT_EN
      ifc.inj_err      = 1'b0;
`endif
      gen_q = prbs13_pkg::GEN_SEED;
      repeat (3) @(posedge clock);
      #1;
      check("rst_locked",    ifc.locked,    1'b0);
      check("rst_err_pulse", ifc.err_pulse, 1'b0);
      check("rst_err_count", ifc.err_count, 16'h0000);
      check("rst_expected",  ifc.expected,  13'h0000);
      @(negedge clock);
      reset = 1'b0;

      // Phases run back to back on one continuous stream; window 0 starts at valid bit 40.
      for (int p = 0; p < 12; p++) begin
         pulses = 0;
         for (int k = 0; k < tbl[p].nbits; k++) begin
            send_gen(((k % 8) == 0) && ((k / 8) < tbl[p].nflips), 1'b0);
         end
         check({tbl[p].name, "_locked"}, ifc.locked,    tbl[p].exp_locked);
         check({tbl[p].name, "_count"},  ifc.err_count, tbl[p].exp_cnt);
         check({tbl[p].name, "_pulses"}, pulses,        tbl[p].exp_pulses);
      end

      // Saturation and clear priority, starting from a fresh window.
      @(negedge clock);
      force dut.err_count_q = 16'hFFFE;
      @(posedge clock);
      @(negedge clock);
      release dut.err_count_q;
      @(posedge clock);
      #1;
      check("sat_preload", ifc.err_count, 16'hFFFE);
      for (int e = 0; e < 3; e++) begin
         send_gen(1'b1, 1'b0);
         send_clean(7);
         check("sat_count", ifc.err_count, 16'hFFFF);
      end
      check("sat_locked", ifc.locked, 1'b1);
      send_gen(1'b1, 1'b1);
      check("clear_vs_err", ifc.err_count, 16'h0000);
      check("clear_lost_lock", ifc.locked, 1'b0);

      // All-zero seed must be rejected and the next 13 bits taken as a new seed.
      do_reset();
      for (int i = 0; i < 13; i++) send(1'b0, 1'b1, 1'b0);
      check("zero_seed_locked",   ifc.locked,   1'b0);
      check("zero_seed_expected", ifc.expected, 13'h0000);
      send_clean(38);
      check("zero_seed_38", ifc.locked, 1'b0);
      send_clean(1);
      check("zero_seed_39", ifc.locked, 1'b1);

      // Reset mid-lock, then relock with random idle gaps.
      send_gen(1'b1, 1'b0);
      check("pre_rst_count", ifc.err_count, 16'h0001);
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_locked",    ifc.locked,    1'b0);
      check("mid_rst_err_pulse", ifc.err_pulse, 1'b0);
      check("mid_rst_err_count", ifc.err_count, 16'h0000);
      check("mid_rst_expected",  ifc.expected,  13'h0000);
      @(negedge clock);
      reset = 1'b0;
      for (int v = 0; v < 39; v++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) send($urandom_range(0, 1), 1'b0, 1'b0);
         if (v == 38) check("gap_relock_38", ifc.locked, 1'b0);
         send_clean(1);
      end
      check("gap_relock_39", ifc.locked, 1'b1);
      send($urandom_range(0, 1), 1'b0, 1'b0);
      check("gap_idle_hold", ifc.locked, 1'b1);
      check("gap_err_count", ifc.err_count, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
